// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host blocks: transmitter FSM states,
// register map, STATUS bit positions and the read-mux slot of the transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    PS2_IDLE      = 3'd0,
    PS2_INHIBIT   = 3'd1,
    PS2_REQ       = 3'd2,
    PS2_SHIFT     = 3'd3,
    PS2_ACK       = 3'd4,
    PS2_WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  localparam logic [31:0] PS2_TX_DATA_OFF = 32'h0;
  localparam logic [31:0] PS2_TX_STAT_OFF = 32'h4;

  localparam int unsigned STAT_BUSY_BIT    = 0;
  localparam int unsigned STAT_ACK_OK_BIT  = 1;
  localparam int unsigned STAT_NACK_BIT    = 2;
  localparam int unsigned STAT_TIMEOUT_BIT = 3;

  // Mirrors RDSEL_PS2_TX in defines_riscv.v; keep both in step.
  localparam logic [3:0] RDSEL_PS2_TX = 4'd9;

  // Index of the stop bit inside the 10-bit host-to-device payload.
  localparam logic [3:0] PS2_STOP_IDX = 4'd9;

  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Multi-stage synchronizer for one PS/2 line with a one-cycle falling-edge
// pulse; shared between the host transmitter and the receiver.
module ps2_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic line_i,
  output logic line_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = SYNC_STAGES'({sync_q, line_i});
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_o = sync_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_tx_ctrl.sv
// Memory-mapped PS/2 host-to-device command transmitter with pollable
// completion, ACK/NACK and timeout status; drives open-drain pull-low enables.
module ps2_tx_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic        we_i,
  output logic [31:0] rdata_o,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic        ps2_clk_oe_o,
  output logic        ps2_dat_oe_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  // INHIBIT_CYCLES must be at least 2 so the start bit lands inside the inhibit.
  localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  logic clk_s, clk_fall, dat_s, dat_fall_unused;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .line_i  (ps2_clk_i),
    .line_o  (clk_s),
    .fall_o  (clk_fall)
  );

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .line_i  (ps2_dat_i),
    .line_o  (dat_s),
    .fall_o  (dat_fall_unused)
  );

  // Bus handshake: we_i is a single-cycle strobe qualified by be_i[0] with no
  // ready/back-pressure. A TXDATA write is taken only in IDLE and dropped
  // otherwise; firmware learns the outcome by polling STATUS.
  logic tx_wr, st_wr;
  assign tx_wr = we_i & be_i[0] & (addr_i[2] == PS2_TX_DATA_OFF[2]);
  assign st_wr = we_i & be_i[0] & (addr_i[2] == PS2_TX_STAT_OFF[2]);

  ps2_tx_state_t    state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       frame_q, frame_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_ok_q, ack_ok_d;
  logic             nack_q, nack_d;
  logic             timeout_q, timeout_d;
  logic             to_hit;

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_ok_d  = ack_ok_q;
    nack_d    = nack_q;
    timeout_d = timeout_q;
    to_hit    = (to_cnt_q == TO_LAST);

    if (st_wr) begin
      ack_ok_d  = 1'b0;
      nack_d    = 1'b0;
      timeout_d = 1'b0;
    end

    unique case (state_q)
      PS2_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_wr) begin
          // Payload in transmit order: data LSB first, parity, stop.
          frame_d   = {1'b1, ps2_odd_parity(wdata_i[7:0]), wdata_i[7:0]};
          inh_cnt_d = '0;
          to_cnt_d  = '0;
          bit_cnt_d = '0;
          clk_oe_d  = 1'b1;
          busy_d    = 1'b1;
          ack_ok_d  = 1'b0;
          nack_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = PS2_INHIBIT;
        end
      end

      PS2_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        if (inh_cnt_q == INH_START) begin
          dat_oe_d = 1'b1;
        end
        if (inh_cnt_q == INH_LAST) begin
          inh_cnt_d = '0;
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b1;
          state_d   = PS2_REQ;
        end
      end

      PS2_REQ: begin
        to_cnt_d  = to_cnt_q + 1'b1;
        bit_cnt_d = '0;
        state_d   = PS2_SHIFT;
        if (to_hit) begin
          timeout_d = 1'b1;
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = PS2_IDLE;
        end
      end

      PS2_SHIFT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (to_hit) begin
          timeout_d = 1'b1;
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = PS2_IDLE;
        end else if (clk_fall) begin
          dat_oe_d  = ~frame_q[0];
          frame_d   = {1'b0, frame_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == PS2_STOP_IDX) begin
            state_d = PS2_ACK;
          end
        end
      end

      PS2_ACK: begin
        to_cnt_d = to_cnt_q + 1'b1;
        dat_oe_d = 1'b0;
        // A device ACK edge outranks a timeout expiring in the same cycle.
        if (clk_fall) begin
          ack_ok_d = ~dat_s;
          nack_d   = dat_s;
          state_d  = PS2_WAIT_IDLE;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          clk_oe_d  = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = PS2_IDLE;
        end
      end

      PS2_WAIT_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (clk_s && dat_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = PS2_IDLE;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = PS2_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= PS2_IDLE;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_ok_q  <= ack_ok_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
    end
  end

  logic [31:0] status;

  always_comb begin
    status                   = '0;
    status[STAT_BUSY_BIT]    = busy_q;
    status[STAT_ACK_OK_BIT]  = ack_ok_q;
    status[STAT_NACK_BIT]    = nack_q;
    status[STAT_TIMEOUT_BIT] = timeout_q;
    rdata_o = (addr_i[2] == PS2_TX_STAT_OFF[2]) ? status : 32'h0;
  end

  assign ps2_clk_oe_o = clk_oe_q;
  assign ps2_dat_oe_o = dat_oe_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{wdata_i[31:8], addr_i[31:3], addr_i[1:0], be_i[3:1]};

endmodule

// File: tb/tb_ps2_tx_ctrl.sv
// Self-checking bench for ps2_tx_ctrl: an open-drain bus with a behavioural
// keyboard model, and a frame reference built from byte/parity arithmetic.
module tb_ps2_tx_ctrl;

  localparam int INH = 20;
  localparam int TMO = 2000;
  localparam int H   = 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] wdata_i, addr_i;
  logic [3:0]  be_i;
  logic        we_i;
  logic [31:0] rdata_o;
  logic        ps2_clk_i, ps2_dat_i;
  logic        ps2_clk_oe_o, ps2_dat_oe_o, busy_o, done_o;
  logic        dev_clk_low, dev_dat_low;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [0:0] exp_q[$];

  ps2_tx_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .wdata_i      (wdata_i),
    .addr_i       (addr_i),
    .be_i         (be_i),
    .we_i         (we_i),
    .rdata_o      (rdata_o),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_dat_i    (ps2_dat_i),
    .ps2_clk_oe_o (ps2_clk_oe_o),
    .ps2_dat_oe_o (ps2_dat_oe_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // ---- clock / reset / bus ----
  always #5 clk_i = ~clk_i;

  assign ps2_clk_i = ~(ps2_clk_oe_o | dev_clk_low);
  assign ps2_dat_i = ~(ps2_dat_oe_o | dev_dat_low);

  always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  // ---- reference model: expected line bits for one byte ----
  function automatic void model_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      ones += int'(b[i]);
    end
    exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
    exp_q.push_back(1'b1);
  endfunction

  // ---- drivers ----
  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk_i);
    addr_i  = addr;
    wdata_i = data;
    be_i    = be;
    we_i    = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0;
    be_i = 4'h0;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] v);
    addr_i = addr;
    #1;
    v = rdata_o;
  endtask

  task automatic dev_falls(input int n, output logic [9:0] seen);
    seen = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk_i);
      dev_clk_low = 1'b0;
      repeat (H / 2) @(negedge clk_i);
      seen[i] = ps2_dat_i;
      repeat (H / 2) @(negedge clk_i);
    end
  endtask

  task automatic dev_ack(input bit ack_low);
    dev_dat_low = ack_low;
    repeat (2) @(negedge clk_i);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk_i);
    dev_clk_low = 1'b0;
    repeat (2) @(negedge clk_i);
    dev_dat_low = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset;
    logic [31:0] v;
    rst_n_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
    dev_clk_low = 1'b0; dev_dat_low = 1'b0;
    repeat (4) @(negedge clk_i);
    n_cmp++;
    if ({ps2_clk_oe_o, ps2_dat_oe_o, busy_o, done_o} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 0000", {ps2_clk_oe_o, ps2_dat_oe_o, busy_o, done_o});
    end
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    read_reg(32'h4, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h expected 0", v); end
    read_reg(32'h0, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL txdata_read: got %h expected 0", v); end
    n_cmp++;
    if (done_cnt !== 0) begin n_err++; $display("FAIL reset_done: got %0d pulses expected 0", done_cnt); end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack_low, input bit intrude, input string tag);
    logic [9:0]  seen;
    logic [31:0] v, exp_st;
    int hi, dat_first, k, d0;
    model_frame(b);
    d0 = done_cnt;
    write_reg(32'h0, {24'h0, b}, 4'h1);
    n_cmp++;
    if (busy_o !== 1'b1) begin n_err++; $display("FAIL busy_rise[%s]: got %b expected 1", tag, busy_o); end
    if (intrude) write_reg(32'h0, 32'h0000_0012, 4'h1);
    hi = 0; dat_first = -1; k = 0;
    while (ps2_clk_oe_o === 1'b1 && k < INH + 40) begin
      if (ps2_dat_oe_o === 1'b1 && dat_first < 0) dat_first = hi;
      hi++; k++;
      @(negedge clk_i);
    end
    if (!intrude) begin
      n_cmp++;
      if (hi !== INH) begin n_err++; $display("FAIL inhibit_len[%s]: got %0d expected %0d", tag, hi, INH); end
      n_cmp++;
      if (dat_first !== INH - 1) begin
        n_err++; $display("FAIL start_bit_cycle[%s]: got %0d expected %0d", tag, dat_first, INH - 1);
      end
    end
    n_cmp++;
    if (ps2_clk_oe_o !== 1'b0 || ps2_dat_i !== 1'b0) begin
      n_err++; $display("FAIL req_lines[%s]: clk_oe=%b dat=%b expected 0 0", tag, ps2_clk_oe_o, ps2_dat_i);
    end
    dev_falls(10, seen);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (seen[i] !== exp_q[i]) begin
        n_err++; $display("FAIL frame_bit[%s] %0d: got %b expected %b", tag, i, seen[i], exp_q[i]);
      end
    end
    read_reg(32'h4, v);
    n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL status_busy[%s]: got %h expected 1", tag, v); end
    dev_ack(ack_low);
    k = 0;
    while (busy_o !== 1'b0 && k < 300) begin @(negedge clk_i); k++; end
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL busy_release[%s]: got %b expected 0", tag, busy_o); end
    repeat (3) @(negedge clk_i);
    exp_st = ack_low ? 32'h2 : 32'h4;
    read_reg(32'h4, v);
    n_cmp++;
    if (v !== exp_st) begin n_err++; $display("FAIL status_end[%s]: got %h expected %h", tag, v, exp_st); end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_err++; $display("FAIL done_pulse[%s]: got %0d cycles expected 1", tag, done_cnt - d0);
    end
    n_cmp++;
    if ({ps2_clk_oe_o, ps2_dat_oe_o} !== 2'b00) begin
      n_err++; $display("FAIL lines_idle[%s]: got %b expected 00", tag, {ps2_clk_oe_o, ps2_dat_oe_o});
    end
  endtask

  task automatic test_ack_f4;
    run_frame(8'hF4, 1'b1, 1'b0, "f4_ack");
  endtask

  task automatic test_nack_ed;
    run_frame(8'hED, 1'b0, 1'b0, "ed_nack");
  endtask

  task automatic test_back_to_back_write;
    run_frame(8'hF4, 1'b1, 1'b1, "busy_write");
  endtask

  task automatic test_timeout;
    logic [31:0] v;
    int k, d0;
    d0 = done_cnt;
    write_reg(32'h0, 32'h0000_00FF, 4'h1);
    k = 0;
    while (ps2_clk_oe_o === 1'b1 && k < INH + 40) begin @(negedge clk_i); k++; end
    repeat (TMO - 50) @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b1) begin n_err++; $display("FAIL timeout_early: busy=%b expected 1", busy_o); end
    k = 0;
    while (busy_o !== 1'b0 && k < 200) begin @(negedge clk_i); k++; end
    n_cmp++;
    if (k < 40 || k > 60) begin n_err++; $display("FAIL timeout_time: got %0d extra cycles expected 40..60", k); end
    repeat (3) @(negedge clk_i);
    read_reg(32'h4, v);
    n_cmp++;
    if (v !== 32'h8) begin n_err++; $display("FAIL timeout_status: got %h expected 8", v); end
    n_cmp++;
    if ({ps2_clk_oe_o, ps2_dat_oe_o} !== 2'b00) begin
      n_err++; $display("FAIL timeout_lines: got %b expected 00", {ps2_clk_oe_o, ps2_dat_oe_o});
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL timeout_done: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    logic [7:0]  b;
    logic [9:0]  seen;
    logic [31:0] v;
    int k;
    b = 8'($urandom_range(0, 255));
    b[4] = 1'b0;
    write_reg(32'h0, {24'h0, b}, 4'h1);
    k = 0;
    while (ps2_clk_oe_o === 1'b1 && k < INH + 40) begin @(negedge clk_i); k++; end
    dev_falls(5, seen);
    n_cmp++;
    if (ps2_dat_oe_o !== 1'b1) begin n_err++; $display("FAIL mid_bit4_driven: got %b expected 1", ps2_dat_oe_o); end
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++;
    if ({ps2_clk_oe_o, ps2_dat_oe_o} !== 2'b00) begin
      n_err++; $display("FAIL async_release: got %b expected 00", {ps2_clk_oe_o, ps2_dat_oe_o});
    end
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    read_reg(32'h4, v);
    n_cmp++;
    if (v !== 32'h0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL post_reset: status=%h busy=%b expected 0 0", v, busy_o);
    end
  endtask

  task automatic test_status_clear;
    logic [31:0] v;
    run_frame(8'hF4, 1'b1, 1'b0, "pre_clear");
    write_reg(32'h4, 32'hFFFF_FFFF, 4'h2);
    read_reg(32'h4, v);
    n_cmp++;
    if (v !== 32'h2) begin n_err++; $display("FAIL clear_be2: got %h expected 2", v); end
    write_reg(32'h4, 32'h0, 4'h1);
    read_reg(32'h4, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL clear_be1: got %h expected 0", v); end
  endtask

  task automatic test_random;
    logic [7:0] b;
    bit ack;
    for (int r = 0; r < 5; r++) begin
      b   = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      run_frame(b, ack, 1'b0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_ack_f4();
    test_nack_ed();
    test_timeout();
    test_back_to_back_write();
    test_reset_mid();
    test_status_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
